// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Conditions the raw slide-switch bus for the switch-to-LED
//            decoder. Each bit is synchronized with two flops and debounced
//            by an independent stability counter. The result is a clean,
//            registered switch vector plus per-bit rise/fall strobes.
//
// Parameters
//   WIDTH            number of switch bits (matches decoder input width)
//   DEBOUNCE_CYCLES  consecutive cycles a changed level must hold before it
//                    is accepted (>= 1)
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   sw_in     in   WIDTH  raw asynchronous switch pins
//   sw_out    out  WIDTH  debounced switch vector (registered)
//   sw_rise   out  WIDTH  one-cycle strobe per bit on sw_out 0->1
//   sw_fall   out  WIDTH  one-cycle strobe per bit on sw_out 1->0
//   changed   out  1      OR of all strobes, aligned with them
//
// Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES; it never goes past
    // DEBOUNCE_CYCLES-1 because acceptance clears it.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer for every bit; only sync2_q is used downstream.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit next-state strobes, gathered so 'changed' can be formed from
    // the same values that are about to be registered as strobes.
    logic [WIDTH-1:0] rise_d_vec;
    logic [WIDTH-1:0] fall_d_vec;
    logic [WIDTH-1:0] out_q_vec;
    logic [WIDTH-1:0] rise_q_vec;
    logic [WIDTH-1:0] fall_q_vec;

    // ------------------------------------------------------------------
    // Independent debounce channel per bit.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_q;
        logic             out_d;
        logic             rise_q;
        logic             rise_d;
        logic             fall_q;
        logic             fall_d;

        always_comb begin
            cnt_d  = cnt_q;
            out_d  = out_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (sync2_q[i] == out_q) begin
                // Input agrees with the accepted level: discard any bounce.
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // Level has differed for DEBOUNCE_CYCLES samples: accept it.
                out_d  = sync2_q[i];
                cnt_d  = '0;
                rise_d = sync2_q[i];
                fall_d = ~sync2_q[i];
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign rise_d_vec[i] = rise_d;
        assign fall_d_vec[i] = fall_d;
        assign out_q_vec[i]  = out_q;
        assign rise_q_vec[i] = rise_q;
        assign fall_q_vec[i] = fall_q;
    end

    // ------------------------------------------------------------------
    // Aggregate change flag, registered alongside the strobes.
    // ------------------------------------------------------------------
    logic changed_q;
    logic changed_d;

    assign changed_d = |(rise_d_vec | fall_d_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign sw_out  = out_q_vec;
    assign sw_rise = rise_q_vec;
    assign sw_fall = fall_q_vec;
    assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Self-checking bench for sw_debounce with DEBOUNCE_CYCLES = 4.
//            Table-driven step sequences plus hand-written reset, bounce,
//            and sweep sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

    localparam int WIDTH = 8;
    localparam int DB    = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;

    int n_cmp = 0;
    int n_err = 0;

    sw_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return {7'd0, sw_out, sw_rise, sw_fall, changed};
    endfunction

    // One full transition: input held for 7 edges, acceptance on edge 6.
    task automatic add_step(input logic [7:0] prev, input logic [7:0] nxt,
                            input logic [7:0] rise, input logic [7:0] fall);
        vec_t v;
        for (int k = 0; k < 7; k++) begin
            v.sw   = nxt;
            v.out  = (k < 5) ? prev : nxt;
            v.rise = (k == 5) ? rise : 8'h00;
            v.fall = (k == 5) ? fall : 8'h00;
            v.chg  = (k == 5);
            tbl.push_back(v);
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 8'h00;

        // ---------------- reset and release ----------------
        #1;
        chk("reset_outputs_init", all_out(), 32'd0);
        step();
        step();
        rst   = 1'b0;
        sw_in = 8'hA5;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e < 6) chk("preload_wait", {24'd0, sw_out}, 32'h00);
        end
        chk("preload_out", {24'd0, sw_out}, 32'hA5);
        chk("preload_rise", {24'd0, sw_rise}, 32'hA5);
        chk("preload_chg", {31'd0, changed}, 32'd1);
        step();
        chk("preload_rise_end", {24'd0, sw_rise}, 32'h00);

        // Mid-cycle asynchronous reset with all switches high.
        #3;
        sw_in = 8'hFF;
        rst   = 1'b1;
        #1;
        chk("async_reset_immediate", all_out(), 32'd0);
        step();
        step();
        chk("reset_held", all_out(), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6) begin
                chk("post_reset_wait", all_out(), 32'd0);
            end else if (e == 6) begin
                chk("post_reset_out", {24'd0, sw_out}, 32'hFF);
                chk("post_reset_rise", {24'd0, sw_rise}, 32'hFF);
                chk("post_reset_fall", {24'd0, sw_fall}, 32'h00);
                chk("post_reset_chg", {31'd0, changed}, 32'd1);
            end else begin
                chk("post_reset_strobe_end", {24'd0, sw_out, sw_rise}, 32'hFF00);
                chk("post_reset_chg_end", {31'd0, changed}, 32'd0);
            end
        end

        // ---------------- table-driven steps ----------------
        add_step(8'hFF, 8'h00, 8'h00, 8'hFF);
        add_step(8'h00, 8'h5A, 8'h5A, 8'h00);   // clean step
        add_step(8'h5A, 8'hF0, 8'hA0, 8'h0A);
        add_step(8'hF0, 8'h0F, 8'h0F, 8'hF0);   // fall and mixed
        add_step(8'h0F, 8'h00, 8'h00, 8'h0F);
        foreach (tbl[k]) begin
            sw_in = tbl[k].sw;
            step();
            chk("tbl_out", {24'd0, sw_out}, {24'd0, tbl[k].out});
            chk("tbl_rise", {24'd0, sw_rise}, {24'd0, tbl[k].rise});
            chk("tbl_fall", {24'd0, sw_fall}, {24'd0, tbl[k].fall});
            chk("tbl_chg", {31'd0, changed}, {31'd0, tbl[k].chg});
        end

        // ---------------- bounce rejection on bit 0 ----------------
        begin
            int runs[4]  = '{3, 1, 3, 10};
            logic lvl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int r = 0; r < 4; r++) begin
                sw_in = {7'd0, lvl[r]};
                for (int c = 0; c < runs[r]; c++) begin
                    step();
                    chk("bounce0_quiet", all_out(), 32'd0);
                end
            end
        end

        // ---------------- bounce then settle on bit 3 ----------------
        begin
            int runs[6]  = '{1, 2, 3, 1, 2, 1};
            logic lvl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            for (int r = 0; r < 6; r++) begin
                sw_in = lvl[r] ? 8'h08 : 8'h00;
                for (int c = 0; c < runs[r]; c++) begin
                    step();
                    chk("bounce3_quiet", all_out(), 32'd0);
                end
            end
            sw_in = 8'h08;
            for (int e = 1; e <= 7; e++) begin
                step();
                if (e < 6) begin
                    chk("settle3_wait", all_out(), 32'd0);
                end else if (e == 6) begin
                    chk("settle3_accept", all_out(), {7'd0, 8'h08, 8'h08, 8'h00, 1'b1});
                end else begin
                    chk("settle3_after", all_out(), {7'd0, 8'h08, 8'h00, 8'h00, 1'b0});
                end
            end
            sw_in = 8'h00;
            repeat (8) step();
            chk("settle3_back_low", {24'd0, sw_out}, 32'h00);
        end

        // ---------------- sweep 0..255 ----------------
        begin
            logic [7:0] prev;
            logic [7:0] cur;
            prev = 8'h00;
            for (int i = 0; i < 256; i++) begin
                cur   = 8'(i);
                sw_in = cur;
                for (int j = 1; j <= 10; j++) begin
                    step();
                    chk("sweep_out", {24'd0, sw_out}, {24'd0, (j < 6) ? prev : cur});
                    if (j == 6)
                        chk("sweep_chg", {31'd0, changed}, {31'd0, (cur != prev)});
                end
                prev = cur;
            end
        end

        // ---------------- reset mid-count abandons the change ----------------
        sw_in = 8'h00;
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        chk("midcount_reset", all_out(), 32'd0);
        step();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("midcount_quiet", all_out(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
